// File: rtl/fu_batch_sink.sv
`default_nettype none
// ============================================================================
// Module      : fu_batch_sink
// Description : Receive side of the core-to-functional-unit batch interface.
//               Queues scheduled batches, splits each into instruction /
//               format / stop fields and issues them to the execute datapath
//               over a valid/ready handshake. On the group end tag the queue
//               is drained and a one-cycle done pulse is returned.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               batch_valid/batch/batch_ready - incoming batch handshake
//               end_tag             - current batch group is complete
//               issue_valid/issue_instr/issue_format/issue_stop/issue_ready
//                                   - issue handshake toward execute
//               done_batches        - one-cycle pulse, group drained
//               issued_count        - non-empty batches issued this group
//               protocol_err        - sticky, batch offered while not ready
//               fu_id               - constant functional unit index
// Revision    : 1.0 - initial release
// ============================================================================
module fu_batch_sink #(
    parameter int FUID              = 0,
    parameter int BATCH_WIDTH       = 64,
    parameter int INSTRUCTION_WIDTH = 44,
    parameter int FORMAT_WIDTH      = 3,
    parameter int QUEUE_DEPTH       = 4    // power of two, >= 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         batch_valid,
    input  logic [BATCH_WIDTH-1:0]       batch,
    output logic                         batch_ready,
    input  logic                         end_tag,
    output logic                         issue_valid,
    output logic [INSTRUCTION_WIDTH-1:0] issue_instr,
    output logic [FORMAT_WIDTH-1:0]      issue_format,
    output logic                         issue_stop,
    input  logic                         issue_ready,
    output logic                         done_batches,
    output logic [15:0]                  issued_count,
    output logic                         protocol_err,
    output logic [7:0]                   fu_id
);

    localparam int c_PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int c_OCC_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = INSTRUCTION_WIDTH + FORMAT_WIDTH + 1;

    localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(QUEUE_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [c_ENTRY_W-1:0] r_mem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [c_OCC_W-1:0]   r_occ;
    logic [15:0]          r_issuedCount;
    logic                 r_protocolErr;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_empty  = (r_occ == '0);
    assign w_full   = (r_occ == c_FULL);
    assign w_accept = batch_valid & batch_ready;
    // An all-zero batch is an empty schedule slot: accepted but never queued.
    assign w_push   = w_accept & (|batch);
    assign w_pop    = issue_valid & issue_ready;

    // Only the fields that are issued are stored; the reserved bits are dropped.
    assign w_entry  = {batch[BATCH_WIDTH-1 -: INSTRUCTION_WIDTH],
                       batch[FORMAT_WIDTH:1],
                       batch[0]};
    assign w_head   = r_mem[r_rdPtr];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                // A batch accepted together with end_tag belongs to the
                // ending group, so it still has to be drained.
                if (w_push) begin
                    w_nextState = end_tag ? c_DRAIN : c_RUN;
                end else if (end_tag && w_empty) begin
                    w_nextState = c_DONE;
                end
            end
            c_RUN: begin
                if (end_tag) begin
                    w_nextState = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_empty && !w_pop) begin
                    w_nextState = c_DONE;
                end
            end
            c_DONE: begin
                w_nextState = c_IDLE;
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        batch_ready  = 1'b0;
        issue_valid  = 1'b0;
        done_batches = 1'b0;
        case (r_state)
            c_IDLE: begin
                batch_ready = 1'b1;
            end
            c_RUN: begin
                // No push-through when full, even if the head pops this cycle.
                batch_ready = !w_full;
                issue_valid = !w_empty;
            end
            c_DRAIN: begin
                issue_valid = !w_empty;
            end
            c_DONE: begin
                done_batches = 1'b1;
            end
            default: begin
                batch_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Batch FIFO: storage is not reset, only pointers and occupancy.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_ONE;
                2'b01:   r_occ <= r_occ - c_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Group statistics and protocol monitor
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_issuedCount <= '0;
        end else if (r_state == c_DONE) begin
            r_issuedCount <= '0;
        end else if (w_pop) begin
            r_issuedCount <= r_issuedCount + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_protocolErr <= 1'b0;
        end else if (batch_valid && !batch_ready) begin
            r_protocolErr <= 1'b1;
        end
    end

    // Issue fields are forced to zero whenever nothing is being offered so
    // stale FIFO contents never appear on the outputs.
    assign issue_instr  = issue_valid ? w_head[c_ENTRY_W-1 -: INSTRUCTION_WIDTH] : '0;
    assign issue_format = issue_valid ? w_head[FORMAT_WIDTH:1] : '0;
    assign issue_stop   = issue_valid ? w_head[0] : 1'b0;

    assign issued_count = r_issuedCount;
    assign protocol_err = r_protocolErr;
    assign fu_id        = 8'(FUID);

endmodule
`default_nettype wire

// File: tb/tb_fu_batch_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_batch_sink
// Description : Directed self-checking bench for fu_batch_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_batch_sink;

    localparam int c_FUID = 5;

    logic        clock;
    logic        reset;
    logic        batch_valid;
    logic [63:0] batch;
    logic        batch_ready;
    logic        end_tag;
    logic        issue_valid;
    logic [43:0] issue_instr;
    logic [2:0]  issue_format;
    logic        issue_stop;
    logic        issue_ready;
    logic        done_batches;
    logic [15:0] issued_count;
    logic        protocol_err;
    logic [7:0]  fu_id;

    int          checks   = 0;
    int          failures = 0;
    int          doneCnt  = 0;
    logic [43:0] popQ [$];

    fu_batch_sink #(
        .FUID              (c_FUID),
        .BATCH_WIDTH       (64),
        .INSTRUCTION_WIDTH (44),
        .FORMAT_WIDTH      (3),
        .QUEUE_DEPTH       (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .batch_valid  (batch_valid),
        .batch        (batch),
        .batch_ready  (batch_ready),
        .end_tag      (end_tag),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .issue_format (issue_format),
        .issue_stop   (issue_stop),
        .issue_ready  (issue_ready),
        .done_batches (done_batches),
        .issued_count (issued_count),
        .protocol_err (protocol_err),
        .fu_id        (fu_id)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change 1 time unit after posedge; everything is observed on negedge.
    always @(negedge clock) begin
        if (issue_valid && issue_ready) popQ.push_back(issue_instr);
        if (done_batches) doneCnt++;
    end

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    // Wait for the done pulse; returns the count visible during the pulse.
    task automatic waitDone(input string tag, input int budget, output logic [15:0] cnt);
        logic seen;
        seen = 1'b0;
        cnt  = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done_batches) begin
                seen = 1'b1;
                cnt  = issued_count;
                break;
            end
        end
        checkValue(tag, 64'(seen), 64'd1);
        nextCycle();
    endtask

    task automatic pushBatch(input logic [63:0] b);
        batch_valid = 1'b1;
        batch       = b;
        nextCycle();
        batch_valid = 1'b0;
        batch       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] bA;
        logic [63:0] bB;
        logic [63:0] bq [5];
        logic [15:0] cnt;
        int          doneBefore;

        reset       = 1'b1;
        batch_valid = 1'b0;
        batch       = '0;
        end_tag     = 1'b0;
        issue_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // ---------------- reset state ----------------
        settle();
        checkValue("rst_issue_valid", 64'(issue_valid), 64'd0);
        checkValue("rst_batch_ready", 64'(batch_ready), 64'd1);
        checkValue("rst_done",        64'(done_batches), 64'd0);
        checkValue("rst_count",       64'(issued_count), 64'd0);
        checkValue("rst_perr",        64'(protocol_err), 64'd0);
        checkValue("rst_fu_id",       64'(fu_id), 64'(c_FUID));
        nextCycle();

        // ---------------- single batch ----------------
        popQ.delete();
        doneBefore  = doneCnt;
        issue_ready = 1'b1;
        batch_valid = 1'b1;
        batch       = 64'h22222222222_00001;
        nextCycle();
        batch_valid = 1'b0;
        batch       = '0;
        settle();
        checkValue("single_valid",  64'(issue_valid), 64'd1);
        checkValue("single_instr",  64'(issue_instr), 64'h22222222222);
        checkValue("single_format", 64'(issue_format), 64'd0);
        checkValue("single_stop",   64'(issue_stop), 64'd1);
        nextCycle();
        end_tag = 1'b1;
        settle();
        checkValue("single_count_pre", 64'(issued_count), 64'd1);
        checkValue("single_empty",     64'(issue_valid), 64'd0);
        nextCycle();
        end_tag = 1'b0;
        settle();
        checkValue("single_drain_nodone", 64'(done_batches), 64'd0);
        nextCycle();
        waitDone("single_done", 10, cnt);
        checkValue("single_count_at_done", 64'(cnt), 64'd1);
        settle();
        checkValue("single_count_clear", 64'(issued_count), 64'd0);
        checkValue("single_done_once",   64'(doneCnt - doneBefore), 64'd1);
        nextCycle();

        // ---------------- empty-slot filtering ----------------
        popQ.delete();
        doneBefore = doneCnt;
        pushBatch(64'h0);
        settle();
        checkValue("empty_slot_no_issue", 64'(issue_valid), 64'd0);
        nextCycle();
        pushBatch(64'h11111111111_00000);
        end_tag = 1'b1;
        nextCycle();
        end_tag = 1'b0;
        waitDone("empty_done", 10, cnt);
        checkValue("empty_count_at_done", 64'(cnt), 64'd1);
        repeat (3) nextCycle();
        checkValue("empty_pops",      64'(popQ.size()), 64'd1);
        checkValue("empty_pop_instr", 64'(popQ.size() > 0 ? popQ[0] : 44'h0), 64'h11111111111);
        checkValue("empty_done_once", 64'(doneCnt - doneBefore), 64'd1);

        // ---------------- end_tag together with accept ----------------
        popQ.delete();
        doneBefore  = doneCnt;
        bA          = 64'h33333333333_00005;
        batch_valid = 1'b1;
        batch       = bA;
        end_tag     = 1'b1;
        nextCycle();
        batch_valid = 1'b0;
        batch       = '0;
        end_tag     = 1'b0;
        settle();
        checkValue("simul_valid",   64'(issue_valid), 64'd1);
        checkValue("simul_format",  64'(issue_format), 64'd2);
        checkValue("simul_no_done", 64'(done_batches), 64'd0);
        nextCycle();
        waitDone("simul_done", 10, cnt);
        checkValue("simul_count_at_done", 64'(cnt), 64'd1);
        checkValue("simul_pops", 64'(popQ.size()), 64'd1);
        checkValue("simul_done_once", 64'(doneCnt - doneBefore), 64'd1);

        // ---------------- repeated end_tag during DRAIN ----------------
        popQ.delete();
        doneBefore  = doneCnt;
        issue_ready = 1'b0;
        bA          = 64'h44444444444_00002;
        bB          = 64'h55555555555_00003;
        pushBatch(bA);
        pushBatch(bB);
        end_tag = 1'b1;
        repeat (3) nextCycle();
        settle();
        checkValue("rep_drain_nodone", 64'(done_batches), 64'd0);
        checkValue("rep_drain_ready",  64'(batch_ready), 64'd0);
        nextCycle();
        end_tag     = 1'b0;
        issue_ready = 1'b1;
        waitDone("rep_done", 10, cnt);
        checkValue("rep_count_at_done", 64'(cnt), 64'd2);
        repeat (3) nextCycle();
        checkValue("rep_done_once", 64'(doneCnt - doneBefore), 64'd1);
        checkValue("rep_pops", 64'(popQ.size()), 64'd2);
        checkValue("rep_order", 64'(popQ.size() > 1 ? popQ[1] : 44'h0), 64'h55555555555);

        // ---------------- backpressure to full ----------------
        popQ.delete();
        doneBefore  = doneCnt;
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bq[i] = {44'(44'hA00000000F0 + 44'(i)), 16'h0, 3'(i), 1'b0};
        end
        for (int i = 0; i < 5; i++) begin
            batch_valid = 1'b1;
            batch       = bq[i];
            settle();
            checkValue($sformatf("full_ready_%0d", i), 64'(batch_ready), (i < 4) ? 64'd1 : 64'd0);
            nextCycle();
        end
        batch_valid = 1'b0;
        batch       = '0;
        settle();
        checkValue("full_perr",       64'(protocol_err), 64'd1);
        checkValue("full_head",       64'(issue_instr), 64'(bq[0][63:20]));
        nextCycle();
        settle();
        checkValue("full_head_stable", 64'(issue_instr), 64'(bq[0][63:20]));
        checkValue("full_still_full",  64'(batch_ready), 64'd0);
        nextCycle();
        issue_ready = 1'b1;
        end_tag     = 1'b1;
        nextCycle();
        end_tag = 1'b0;
        waitDone("full_done", 20, cnt);
        checkValue("full_count_at_done", 64'(cnt), 64'd4);
        checkValue("full_pops", 64'(popQ.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkValue($sformatf("full_order_%0d", i),
                       64'(popQ.size() > i ? popQ[i] : 44'h0), 64'(bq[i][63:20]));
        end
        checkValue("full_perr_sticky", 64'(protocol_err), 64'd1);

        // ---------------- mid-group reset ----------------
        popQ.delete();
        issue_ready = 1'b0;
        pushBatch(64'h66666666666_00001);
        pushBatch(64'h77777777777_00001);
        pushBatch(64'h88888888888_00001);
        settle();
        checkValue("mid_valid_before", 64'(issue_valid), 64'd1);
        doneBefore = doneCnt;
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        settle();
        checkValue("mid_issue_valid", 64'(issue_valid), 64'd0);
        checkValue("mid_batch_ready", 64'(batch_ready), 64'd1);
        checkValue("mid_perr_clear",  64'(protocol_err), 64'd0);
        checkValue("mid_count_clear", 64'(issued_count), 64'd0);
        issue_ready = 1'b1;
        repeat (4) nextCycle();
        settle();
        checkValue("mid_no_done",     64'(doneCnt - doneBefore), 64'd0);
        checkValue("mid_still_empty", 64'(issue_valid), 64'd0);
        checkValue("mid_no_pops",     64'(popQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
